// File: rtl/mmcm_phase_stepper.sv
// Shared dynamic phase-shift stepper for several MMCMs: moves each channel's fine
// phase one PSEN step at a time toward an absolute target along the shortest wrap.
module mmcm_phase_stepper #(
  parameter int unsigned pCHANNELS    = 2,
  parameter int unsigned pPHASE_WIDTH = 9,
  parameter int unsigned pSTEPS       = 448,
  parameter int unsigned pTIMEOUT     = 64
) (
  input  logic                              clk_usb,
  input  logic                              reset,
  input  logic [pCHANNELS-1:0]              load_i,
  input  logic [pCHANNELS*pPHASE_WIDTH-1:0] phase_req_i,
  output logic [pCHANNELS*pPHASE_WIDTH-1:0] phase_actual_o,
  output logic [pCHANNELS-1:0]              done_o,
  output logic [pCHANNELS-1:0]              error_o,
  output logic                              busy_o,
  input  logic [pCHANNELS-1:0]              locked_i,
  output logic [pCHANNELS-1:0]              psen_o,
  output logic [pCHANNELS-1:0]              psincdec_o,
  input  logic [pCHANNELS-1:0]              psdone_i
);

  localparam int NCH = int'(pCHANNELS);
  localparam int W   = int'(pPHASE_WIDTH);
  localparam int WE  = W + 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

  localparam logic [W:0]    M_EXT   = WE'(pSTEPS);
  localparam logic [W:0]    HALF    = WE'(pSTEPS / 2);
  localparam logic [W-1:0]  M_LAST  = W'(pSTEPS - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(pTIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   sel;
  logic [CW-1:0]   rr;
  logic            dir;
  logic [TW-1:0]   timer;
  logic [W-1:0]    target_q [NCH];
  logic [W-1:0]    actual_q [NCH];
  logic [W-1:0]    target_d [NCH];
  logic [W-1:0]    actual_d [NCH];
  logic [NCH-1:0]  pend_q, pend_d, err_d, done_d, locked_q;
  logic [NCH-1:0]  lock_fall, steppable, inc;
  logic            ack, tmo, abandon, pick_found, busy_d;
  logic [CW-1:0]   pick_idx;

  assign lock_fall = locked_q & ~locked_i;

  // Per-channel shortest-direction decision; the half-period tie increments.
  always_comb begin
    logic [W:0] diff;
    diff      = '0;
    steppable = '0;
    inc       = '0;
    for (int c = 0; c < NCH; c++) begin
      if (target_q[c] >= actual_q[c]) diff = {1'b0, target_q[c]} - {1'b0, actual_q[c]};
      else                            diff = {1'b0, target_q[c]} + M_EXT - {1'b0, actual_q[c]};
      inc[c]       = (diff <= HALF);
      steppable[c] = (target_q[c] != actual_q[c]) && locked_i[c];
    end
  end

  // Step outcome for the selected channel and round-robin pick starting at rr.
  always_comb begin
    logic [CW-1:0] cand;
    int            k;
    cand       = '0;
    k          = 0;
    ack        = (state == S_WAIT) && psdone_i[sel] && !lock_fall[sel];
    tmo        = (state == S_WAIT) && !psdone_i[sel] && !lock_fall[sel] && (timer == T_LAST);
    abandon    = (state != S_IDLE) && lock_fall[sel];
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = int'(rr) + i;
      if (k >= NCH) k = k - NCH;
      cand = CW'(k);
      if (steppable[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next per-channel state: lock loss, step completion, timeout, load, then done.
  always_comb begin
    logic [W-1:0] req;
    req      = '0;
    target_d = target_q;
    actual_d = actual_q;
    pend_d   = pend_q;
    err_d    = error_o;
    done_d   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (lock_fall[c]) begin
        actual_d[c] = '0;
      end else if (ack && (sel == CW'(c))) begin
        if (dir) actual_d[c] = (actual_q[c] == M_LAST) ? '0 : actual_q[c] + W'(1);
        else     actual_d[c] = (actual_q[c] == '0) ? M_LAST : actual_q[c] - W'(1);
      end
      if (tmo && (sel == CW'(c))) begin
        err_d[c]    = 1'b1;
        target_d[c] = actual_d[c];
      end
      if (load_i[c]) begin
        req = phase_req_i[c*W +: W];
        if ({1'b0, req} < M_EXT) begin
          target_d[c] = req;
          pend_d[c]   = 1'b1;
          err_d[c]    = 1'b0;
        end else begin
          err_d[c]  = 1'b1;
          done_d[c] = 1'b1;
        end
      end
      if (pend_d[c] && (actual_d[c] == target_d[c])) begin
        done_d[c] = 1'b1;
        pend_d[c] = 1'b0;
      end
    end
    busy_d = ((state == S_IDLE) ? pick_found : !(ack || tmo || abandon)) || (|pend_d);
  end

  always_comb begin
    phase_actual_o = '0;
    for (int c = 0; c < NCH; c++) phase_actual_o[c*W +: W] = actual_q[c];
  end

  always_ff @(posedge clk_usb or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= '0;
      rr         <= '0;
      dir        <= 1'b0;
      timer      <= '0;
      pend_q     <= '0;
      locked_q   <= '0;
      error_o    <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
      psen_o     <= '0;
      psincdec_o <= '0;
      for (int c = 0; c < NCH; c++) begin
        target_q[c] <= '0;
        actual_q[c] <= '0;
      end
    end else begin
      target_q   <= target_d;
      actual_q   <= actual_d;
      pend_q     <= pend_d;
      error_o    <= err_d;
      done_o     <= done_d;
      busy_o     <= busy_d;
      locked_q   <= locked_i;
      psen_o     <= '0;
      psincdec_o <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            sel                  <= pick_idx;
            dir                  <= inc[pick_idx];
            psen_o[pick_idx]     <= 1'b1;
            psincdec_o[pick_idx] <= inc[pick_idx];
            timer                <= '0;
            state                <= S_STEP;
          end
        end
        S_STEP: begin
          timer <= timer + TW'(1);
          state <= abandon ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (abandon || tmo) begin
            state <= S_IDLE;
          end else if (ack) begin
            rr    <= (sel == CH_LAST) ? '0 : sel + CW'(1);
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_phase_stepper.sv
// Scoreboard bench for mmcm_phase_stepper: expected PSEN steps and done pulses are
// queued when a load is issued and consumed by a monitor as the DUT produces them.
module tb_mmcm_phase_stepper;

  localparam int C   = 2;
  localparam int W   = 9;
  localparam int M   = 448;
  localparam int TMO = 64;

  logic           clk_usb = 1'b0;
  logic           reset;
  logic [C-1:0]   load_i;
  logic [C*W-1:0] phase_req_i;
  logic [C*W-1:0] phase_actual_o;
  logic [C-1:0]   done_o, error_o, locked_i, psen_o, psincdec_o;
  logic [C-1:0]   psdone_i = '0;
  logic           busy_o;

  typedef struct packed {
    logic [31:0] ch;
    logic        inc;
  } step_t;

  step_t        exp_step[$];
  int           exp_done[$];
  step_t        mon_s;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [C-1:0] resp_en;
  int           cnt[C] = '{default: 0};

  mmcm_phase_stepper #(
    .pCHANNELS(C), .pPHASE_WIDTH(W), .pSTEPS(M), .pTIMEOUT(TMO)
  ) dut (
    .clk_usb(clk_usb), .reset(reset), .load_i(load_i), .phase_req_i(phase_req_i),
    .phase_actual_o(phase_actual_o), .done_o(done_o), .error_o(error_o), .busy_o(busy_o),
    .locked_i(locked_i), .psen_o(psen_o), .psincdec_o(psincdec_o), .psdone_i(psdone_i)
  );

  always #5 clk_usb = ~clk_usb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] act(input int ch);
    return 32'(phase_actual_o[ch*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic load(input logic [C-1:0] m, input logic [W-1:0] v0, input logic [W-1:0] v1);
    load_i      = m;
    phase_req_i = {v1, v0};
    tick();
    load_i = '0;
  endtask

  // Reference walk: shortest wrap direction re-evaluated before every step.
  task automatic plan(input int ch, input int from, input int to);
    int    cur = from;
    int    d;
    step_t s;
    while (cur != to) begin
      d     = (to - cur + M) % M;
      s.ch  = 32'(ch);
      s.inc = (d <= M / 2);
      exp_step.push_back(s);
      cur = s.inc ? (cur + 1) % M : (cur + M - 1) % M;
    end
    exp_done.push_back(ch);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy_o || exp_step.size() != 0 || exp_done.size() != 0) && k < budget) begin
      @(negedge clk_usb);
      #1;
      k++;
    end
    check("settle", 32'(!busy_o && exp_step.size() == 0 && exp_done.size() == 0), 1);
    tick();
  endtask

  task automatic wait_psen(input int ch);
    int k = 0;
    while (!psen_o[ch] && k < 20) begin
      tick();
      k++;
    end
    check("psen_seen", 32'(psen_o[ch]), 1);
  endtask

  // MMCM model: PSDONE three cycles after each accepted PSEN.
  always @(posedge clk_usb) begin
    #1;
    for (int c = 0; c < C; c++) begin
      psdone_i[c] = 1'b0;
      if (cnt[c] > 0) begin
        cnt[c]--;
        if (cnt[c] == 0) psdone_i[c] = 1'b1;
      end
      if (psen_o[c] && resp_en[c]) cnt[c] = 3;
    end
  end

  always @(negedge clk_usb) begin
    if (!reset) begin
      check("incdec_mask", 32'(psincdec_o & ~psen_o), 0);
      if (psen_o != '0) begin
        if (exp_step.size() == 0) check("psen_unexp", 32'(psen_o), 0);
        else begin
          mon_s = exp_step.pop_front();
          check("psen_ch", 32'(psen_o), 32'(1) << mon_s.ch);
          check("psincdec", 32'(psincdec_o), mon_s.inc ? (32'(1) << mon_s.ch) : 32'(0));
        end
      end
      for (int c = 0; c < C; c++) begin
        if (done_o[c]) begin
          if (exp_done.size() == 0) check("done_unexp", 32'(c), 32'hFFFF_FFFF);
          else check("done_ch", 32'(c), 32'(exp_done.pop_front()));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    load_i      = '0;
    phase_req_i = '0;
    locked_i    = '1;
    resp_en     = '1;
    repeat (3) tick();
    check("rst_actual", 32'(phase_actual_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_psen", 32'(psen_o), 0);
    check("rst_incdec", 32'(psincdec_o), 0);
    reset = 1'b0;
    tick();

    // Simple increment 0 -> 5 with load-to-psen latency.
    plan(0, 0, 5);
    load(2'b01, 9'd5, 9'd0);
    check("t1_busy_n1", 32'(busy_o), 1);
    check("t1_psen_n1", 32'(psen_o), 0);
    tick();
    check("t1_psen_n2", 32'(psen_o), 1);
    wait_idle(200);
    check("t1_actual", act(0), 5);

    // Decrement through zero: 2 -> 446.
    plan(0, 5, 2);
    load(2'b01, 9'd2, 9'd0);
    wait_idle(200);
    plan(0, 2, 446);
    load(2'b01, 9'd446, 9'd0);
    wait_idle(200);
    check("t2_actual", act(0), 446);

    // Wrap forward to 0, then the half-period tie.
    plan(0, 446, 0);
    load(2'b01, 9'd0, 9'd0);
    wait_idle(200);
    check("t3_zero", act(0), 0);
    plan(0, 0, 224);
    load(2'b01, 9'd224, 9'd0);
    wait_idle(2000);
    check("t3_tie", act(0), 224);

    // Out-of-range request, then a request equal to the current phase.
    exp_done.push_back(0);
    load(2'b01, 9'd448, 9'd0);
    check("inv_err", 32'(error_o[0]), 1);
    check("inv_done", 32'(done_o[0]), 1);
    check("inv_busy", 32'(busy_o), 0);
    repeat (10) tick();
    check("inv_hold", act(0), 224);
    wait_idle(10);
    plan(0, 224, 224);
    load(2'b01, 9'd224, 9'd0);
    check("eq_done", 32'(done_o[0]), 1);
    check("eq_err_clr", 32'(error_o[0]), 0);
    wait_idle(10);

    // Reset during a step; the late PSDONE must not move anything.
    plan(0, 224, 230);
    load(2'b01, 9'd230, 9'd0);
    wait_psen(0);
    tick();
    reset = 1'b1;
    exp_step.delete();
    exp_done.delete();
    tick();
    check("mid_rst_psen", 32'(psen_o), 0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("mid_rst_actual", act(0), 0);
    check("mid_rst_busy", 32'(busy_o), 0);

    // Round-robin between both channels loaded together.
    for (int i = 0; i < 3; i++) begin
      exp_step.push_back('{32'd0, 1'b1});
      exp_step.push_back('{32'd1, 1'b1});
    end
    exp_done.push_back(0);
    exp_done.push_back(1);
    load(2'b11, 9'd3, 9'd3);
    wait_idle(300);
    check("rr_act0", act(0), 3);
    check("rr_act1", act(1), 3);

    // PSDONE withheld: timeout at psen+64.
    resp_en[0] = 1'b0;
    exp_step.push_back('{32'd0, 1'b1});
    exp_done.push_back(0);
    load(2'b01, 9'd10, 9'd0);
    wait_psen(0);
    repeat (TMO - 1) tick();
    check("tmo_early", 32'(error_o[0]), 0);
    tick();
    check("tmo_err", 32'(error_o[0]), 1);
    check("tmo_done", 32'(done_o[0]), 1);
    check("tmo_actual", act(0), 3);
    repeat (5) tick();
    check("tmo_busy", 32'(busy_o), 0);
    resp_en[0] = 1'b1;
    plan(0, 3, 10);
    load(2'b01, 9'd10, 9'd0);
    check("tmo_clear", 32'(error_o[0]), 0);
    wait_idle(200);
    check("tmo_reload", act(0), 10);

    // Lock loss mid-wait at 10 heading to 20, then relock.
    resp_en[0] = 1'b0;
    exp_step.push_back('{32'd0, 1'b1});
    load(2'b01, 9'd20, 9'd0);
    wait_psen(0);
    tick();
    locked_i[0] = 1'b0;
    tick();
    tick();
    check("lol_actual", act(0), 0);
    check("lol_err", 32'(error_o[0]), 0);
    check("lol_busy", 32'(busy_o), 1);
    repeat (20) tick();
    plan(0, 0, 20);
    resp_en[0]  = 1'b1;
    locked_i[0] = 1'b1;
    wait_idle(400);
    check("lol_final", act(0), 20);
    check("lol_err_end", 32'(error_o[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmcm_phase_stepper.md
# mmcm_phase_stepper

Multi-channel dynamic phase-shift controller for the ADC-clock and clkgen MMCMs, living alongside the clock-management block. It replaces the tied-off PSEN/PSINCDEC path with a parametrised, shared stepper. The stepper accepts an absolute phase target per channel and drives each MMCM's fine phase-shift port one step at a time. It always takes the shortest wrap-around direction, and it handles PSDONE timeouts and loss of lock. Register-side phase_requested / phase_actual / phase_load / phase_done map onto one channel each.

## Interface
Parameters:
- pCHANNELS, 2, number of MMCMs controlled.
- pPHASE_WIDTH, 9, bits per phase value; 2^pPHASE_WIDTH >= pSTEPS required.
- pSTEPS, 448, fine steps per full clock period (modulus M).
- pTIMEOUT, 64, clk_usb cycles allowed between psen and psdone.

Ports:
- clk_usb  input  1  sole clock; same as MMCM psclk.
- reset  input  1  asynchronous, active-high.
- load_i  input  pCHANNELS  per-channel load strobe, one cycle.
- phase_req_i  input  pCHANNELS*pPHASE_WIDTH  packed targets, channel c at [c*W +: W].
- phase_actual_o  output  pCHANNELS*pPHASE_WIDTH  current tracked phase per channel.
- done_o  output  pCHANNELS  one-cycle pulse when a load completes.
- error_o  output  pCHANNELS  sticky: invalid request or timeout.
- busy_o  output  1  FSM not in IDLE, or any channel pending.
- locked_i  input  pCHANNELS  MMCM LOCKED, already synchronised to clk_usb.
- psen_o  output  pCHANNELS  MMCM PSEN.
- psincdec_o  output  pCHANNELS  MMCM PSINCDEC; 1 = increment.
- psdone_i  input  pCHANNELS  MMCM PSDONE.

## Operation
- Per-channel registers: target[c], actual[c], pend[c] (load awaiting done), error[c].
- Load of channel c with req < M: target := req, pend := 1, error := 0. Load with req >= M: target unchanged, error := 1, done pulse, pend unchanged.
- A channel is steppable when target != actual and locked_i[c] = 1.
- FSM states:
  - IDLE: if any channel is steppable, pick the next one at or after rr_ptr (round-robin). Latch sel and dir, then go to STEP.
  - STEP: psen_o[sel] = 1 for exactly one cycle, psincdec_o[sel] = dir, timer := 0. Go to WAIT.
  - WAIT:
    - On psdone_i[sel]: actual := actual ± 1 mod M, rr_ptr := sel+1 mod pCHANNELS, go to IDLE.
    - Else, when timer = pTIMEOUT-1: error[sel] := 1, target[sel] := actual[sel], go to IDLE.
- Direction: d = (target − actual) mod M. If d <= M/2, increment; otherwise decrement. The tie at d = M/2 increments.
- Wrap: increment of M−1 gives 0; decrement of 0 gives M−1.
- Done: when pend[c] = 1 and actual[c] = target[c] (after a step, a timeout, or at load when already equal), pulse done_o[c] and clear pend[c].
- Load on the channel currently in WAIT: the new target is latched immediately. The in-flight step completes, and the next step uses the new direction.
- Simultaneous load on several channels: all are latched in the same cycle.
- Loss of lock: on a falling edge of locked_i[c], actual[c] := 0, because the MMCM resets to zero phase. The target is kept. If c is in WAIT, the wait is abandoned without error and the FSM returns to IDLE. Stepping resumes after relock.
- psen_o and psincdec_o are only ever asserted on the channel sel; all other channels hold 0.
- psdone_i on a channel that is not in WAIT is ignored.

## Timing
- Reset values: all outputs 0, actual = target = 0, pend = 0, error = 0, rr_ptr = 0, FSM in IDLE.
- Reset mid-step returns immediately to IDLE; a late psdone after reset is ignored.
- Load in cycle n: target is visible at n+1, IDLE selects at n+1, psen is high in cycle n+2.
- psdone in cycle k: actual updates at the k+1 edge. The done pulse, if this was the final step, occurs in cycle k+1. The next psen is no earlier than k+2.
- A load with req = actual in cycle n gives a done pulse in cycle n+1.
- Per step: 2 + (psdone latency) cycles. A full move of s steps costs s × that.
- Timeout: error is set in cycle t+pTIMEOUT, where t is the psen cycle.
- busy_o asserts at n+1 after a steppable load and falls in the same cycle as the last done pulse.

## Test plan
- Ch0, actual 0, load 5, psdone returned 3 cycles after each psen: expect 5 increments, actual 5, one done pulse, psen never on ch1.
- Ch0 actual 2, load 446 (M = 448): expect 4 decrements through 1, 0, 447, 446, then done.
- Tie and invalid requests: from 0, load 224 gives 224 increments. Load 448 gives error_o[0] = 1 and a done pulse at n+1, with target unchanged.
- Round-robin: load ch0 = 3 and ch1 = 3 in the same cycle. Expect psen alternating ch0, ch1, ch0, …; both done pulses arrive, ch1's last.
- Timeout: psdone withheld. Expect error_o[0] at psen+64, target == actual, and a done pulse. A subsequent valid load clears the error.
- Lock loss at actual 10 with target 20: drop locked_i[0] mid-WAIT. Expect actual 0 and no psen while unlocked. After relock, 20 increments, then done.
